alu_seq_driver: RTL and testbench
=================================

# alu_seq_driver

Command-driven initiator for the 16-bit ALU: it accepts a multi-word operation on a valid/ready request port and issues it to an external `ALU_16bit` one 16-bit word per cycle. It chains carry between words and returns the assembled result on a valid/ready response port. It sits between a control unit (or bench) and the combinational ALU, and is the consumer/driver end of the ALU's operand/result interface.

## Interface
- `NWORDS`, default 2: number of 16-bit words per operand; legal range 1–4; operand width `W = 16*NWORDS`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: engine idle and can accept.
- `req_op` in 2: operation select; 00 AND, 01 ADD, 10 SUB, 11 SLT.
- `req_a`, `req_b` in W: operands, two's complement.
- `alu_a`, `alu_b` out 16: word operands to the ALU.
- `alu_cin` out 1: ALU carry-in.
- `alu_sub` out 1: ALU subtract control; always driven 0.
- `alu_op` out 3: ALU operation; 000 for AND, 100 for ADD/SUB/SLT.
- `alu_result` in 16: ALU result, combinational from the `alu_*` outputs.
- `alu_cout` in 1: ALU carry-out.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumer accepts.
- `rsp_result` out W: assembled result.
- `rsp_cout` out 1: final carry-out.
- `rsp_less` out 1: signed A<B.

## Operation
- States: IDLE, EXEC, DONE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`&`req_ready`, latch op, A, and B′, clear word index k=0, go to EXEC.
  - For SUB/SLT, B′ = ~B (engine inverts); otherwise B′ = B.
- EXEC, word k (LSW first):
  - `alu_a` = A[16k+15:16k] and `alu_b` = B′ word k, both muxed combinationally from registered state.
  - `alu_cin`: word 0 = 1 for SUB/SLT, 0 otherwise; word k>0 = registered carry from word k−1. AND always drives 0.
  - At the clock edge, capture `alu_result` into result word k and `alu_cout` into the carry register, then k++.
  - After word NWORDS−1, go to DONE.
- DONE:
  - `rsp_valid`=1.
  - Result and flags are held stable until `rsp_valid`&`rsp_ready`, then go to IDLE.
  - `req_ready`=0 in EXEC and DONE; no overlap of requests.
- Flags:
  - AND: `rsp_cout`=0, `rsp_less`=0.
  - ADD: `rsp_cout` = final carry, `rsp_less`=0.
  - SUB/SLT: `rsp_cout` = final carry (1 means no borrow). `rsp_less` = N xor V, where N = result MSB and V = (A[W−1] != B[W−1]) & (N != A[W−1]), using the original B.
- SLT: `rsp_result` = {W−1 zeros, `rsp_less`}.
- Arithmetic wraps modulo 2^W.
- Outputs are idle-safe: when not in EXEC, `alu_a`/`alu_b`/`alu_cin`/`alu_op`=0.

## Timing
- Reset values:
  - `rsp_valid`=0, `rsp_result`=0, `rsp_cout`=0, `rsp_less`=0.
  - All `alu_*` outputs 0; state IDLE.
  - `req_ready`=0 while `rst` is high, and 1 from the first cycle after deassertion.
- Latency: with the request handshake at edge E0, `rsp_valid` rises after edge E0+NWORDS. For NWORDS=2, this is 2 cycles.
- Response handshake at edge Ed: `req_ready`=1 from Ed onward. The next request can be accepted at the first edge after Ed, so minimum initiation interval is NWORDS+2 cycles.
- `req_*` inputs are sampled only at the handshake edge; changes afterwards are ignored.
- Reset asserted in EXEC or DONE aborts the operation immediately; no response is produced.
- `rsp_ready` held high before DONE has no effect.

## Configuration
- `ALU_SEQ_SLT_EN` defined: op 11 is SLT as specified above.
- `ALU_SEQ_SLT_EN` undefined: op 11 behaves exactly as SUB (full difference returned in `rsp_result`, flags as for SUB); no SLT result mux is built.

## Test plan
- AND A=0xAAAAAAAA, B=0x55555555 -> `rsp_result`=0x00000000, cout=0, less=0; `rsp_valid` 2 cycles after handshake.
- ADD A=0x0000FFFF, B=0x00000001 -> word0 `alu_cin`=0, word1 `alu_cin`=1; `rsp_result`=0x00010000, cout=0.
- SUB A=0x80000000, B=0x00000001 -> `rsp_result`=0x7FFFFFFF, cout=1, less=1 (overflow case). With `ALU_SEQ_SLT_EN`, SLT on the same operands -> `rsp_result`=0x00000001.
- SUB A=0x7FFFFFFF, B=0xFFFFFFFE -> `rsp_result`=0x80000001, cout=0, less=0; `alu_op`=100 and `alu_sub`=0 on both words.
- Backpressure: hold `rsp_ready`=0 for 3 cycles in DONE -> `rsp_result`/flags stable and `req_ready`=0 throughout; a new `req_valid` pulse is ignored; after `rsp_ready`=1, back to IDLE.
- Assert `rst` during EXEC word 1 -> all outputs 0 asynchronously, no `rsp_valid`; the next request completes normally.

Source files
------------

// File: rtl/alu_seq_driver_if.sv
// Purpose: bundles the request, response and ALU word-port signals of alu_seq_driver.
// Ports: req_* (request, valid/ready), rsp_* (response, valid/ready), alu_* (word operands/result).
// Modports: slave = the sequencing engine; master = requester plus the combinational ALU.
interface alu_seq_driver_if #(
  parameter int NWORDS = 2
);
  localparam int W = 16 * NWORDS;

  logic           req_valid;
  logic           req_ready;
  logic [1:0]     req_op;
  logic [W-1:0]   req_a;
  logic [W-1:0]   req_b;

  logic [15:0]    alu_a;
  logic [15:0]    alu_b;
  logic           alu_cin;
  logic           alu_sub;
  logic [2:0]     alu_op;
  logic [15:0]    alu_result;
  logic           alu_cout;

  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_result;
  logic           rsp_cout;
  logic           rsp_less;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, alu_result, alu_cout,
    output req_ready, alu_a, alu_b, alu_cin, alu_sub, alu_op,
           rsp_valid, rsp_result, rsp_cout, rsp_less
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, alu_result, alu_cout,
    input  req_ready, alu_a, alu_b, alu_cin, alu_sub, alu_op,
           rsp_valid, rsp_result, rsp_cout, rsp_less
  );
endinterface

// File: rtl/alu_seq_driver.sv
// Purpose: issues a NWORDS x 16-bit AND/ADD/SUB/SLT to an external 16-bit ALU, LSW first, chaining carry.
// Ports: clk, rst (async active-high), bus (alu_seq_driver_if.slave: req_*, alu_*, rsp_*).
// Latency: rsp_valid rises NWORDS cycles after the request handshake; one request in flight at a time.
// Option: define ALU_SEQ_SLT_EN to make op 11 return {0.., less}; otherwise op 11 acts as SUB.
module alu_seq_driver #(
  parameter int NWORDS = 2
) (
  input  logic              clk,
  input  logic              rst,
  alu_seq_driver_if.slave   bus
);
  localparam int W = 16 * NWORDS;

  localparam logic [1:0] OP_AND = 2'b00;
`ifdef ALU_SEQ_SLT_EN
  localparam logic [1:0] OP_SLT = 2'b11;
`endif

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t          state_q;
  state_t          state_d;
  logic [1:0]      op_q;
  logic [1:0]      k_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;       // already inverted for SUB/SLT
  logic            b_msb_q;   // MSB of the original B, for the overflow term
  logic [W-1:0]    res_q;
  logic            carry_q;
  logic            cout_q;
  logic            less_q;

  logic            ready_c;
  logic            valid_c;
  logic            accept;
  logic            last_word;
  logic            is_and;
  logic            is_sub;
  logic [W-1:0]    res_d;
  logic            n_flag;
  logic            v_flag;
  logic            less_d;

  assign is_and    = (op_q == OP_AND);
  assign is_sub    = op_q[1];               // 10 SUB and 11 SLT both subtract
  assign last_word = (k_q == 2'(NWORDS - 1));
  assign accept    = bus.req_valid & bus.req_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake outputs
  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.req_valid & ~rst) state_d = EXEC;
      end
      EXEC: begin
        if (last_word) state_d = DONE;
      end
      DONE: begin
        valid_c = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Held low while reset is asserted even though the state already reads IDLE.
  assign bus.req_ready = ready_c & ~rst;
  assign bus.rsp_valid = valid_c;

  // Word mux to the ALU; everything is zero outside EXEC.
  always_comb begin
    bus.alu_a   = 16'h0000;
    bus.alu_b   = 16'h0000;
    bus.alu_cin = 1'b0;
    bus.alu_sub = 1'b0;
    bus.alu_op  = 3'b000;
    if (state_q == EXEC) begin
      for (int i = 0; i < NWORDS; i++) begin
        if (k_q == i[1:0]) begin
          bus.alu_a = a_q[16*i +: 16];
          bus.alu_b = b_q[16*i +: 16];
        end
      end
      bus.alu_op = is_and ? 3'b000 : 3'b100;
      if (!is_and)
        bus.alu_cin = (k_q == 2'd0) ? is_sub : carry_q;
    end
  end

  // Result with the current ALU word merged in, used for the final flags.
  always_comb begin
    res_d = res_q;
    for (int i = 0; i < NWORDS; i++) begin
      if (k_q == i[1:0]) res_d[16*i +: 16] = bus.alu_result;
    end
  end

  assign n_flag = res_d[W-1];
  assign v_flag = (a_q[W-1] != b_msb_q) & (n_flag != a_q[W-1]);
  assign less_d = n_flag ^ v_flag;

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= 2'b00;
      k_q     <= 2'd0;
      a_q     <= '0;
      b_q     <= '0;
      b_msb_q <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      less_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q    <= bus.req_op;
            a_q     <= bus.req_a;
            b_q     <= bus.req_op[1] ? ~bus.req_b : bus.req_b;
            b_msb_q <= bus.req_b[W-1];
            k_q     <= 2'd0;
            carry_q <= 1'b0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            less_q  <= 1'b0;
          end
        end
        EXEC: begin
          res_q   <= res_d;
          carry_q <= bus.alu_cout;
          k_q     <= k_q + 2'd1;
          if (last_word) begin
            cout_q <= is_and ? 1'b0 : bus.alu_cout;
            less_q <= is_sub ? less_d : 1'b0;
`ifdef ALU_SEQ_SLT_EN
            if (op_q == OP_SLT) res_q <= {{(W-1){1'b0}}, less_d};
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_result = res_q;
  assign bus.rsp_cout   = cout_q;
  assign bus.rsp_less   = less_q;
endmodule

// File: tb/tb_alu_seq_driver.sv
// Purpose: directed self-checking bench for alu_seq_driver (NWORDS=2) with a behavioural 16-bit ALU.
// Ports: none; drives the interface master side and models ALU_16bit combinationally.
// Covers reset, AND/ADD/SUB/SLT vectors, latency, backpressure, early rsp_ready, reset mid-operation.
module tb_alu_seq_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [15:0] tr_a   [2];
  logic [15:0] tr_b   [2];
  logic        tr_cin [2];
  logic        tr_sub [2];
  logic [2:0]  tr_op  [2];

`ifdef ALU_SEQ_SLT_EN
  localparam logic [31:0] SLT_EXP = 32'h0000_0001;
`else
  localparam logic [31:0] SLT_EXP = 32'h7FFF_FFFF;
`endif

  always #5 clk = ~clk;

  alu_seq_driver_if #(.NWORDS(2)) bus ();

  alu_seq_driver #(.NWORDS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural 16-bit ALU: 000 = AND, 100 = add with carry-in.
  always_comb begin
    logic [16:0] sum;
    sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {16'h0000, bus.alu_cin};
    if (bus.alu_op == 3'b000) begin
      bus.alu_result = bus.alu_a & bus.alu_b;
      bus.alu_cout   = 1'b0;
    end else begin
      bus.alu_result = sum[15:0];
      bus.alu_cout   = sum[16];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (bus.req_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("req_ready_wait", {63'd0, bus.req_ready}, 64'd1);
  endtask

  // Handshake one request and trace both EXEC words; ends at the first negedge in DONE.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_op    = 2'($urandom);
    bus.req_a     = $urandom;
    bus.req_b     = $urandom;
    for (int w = 0; w < 2; w++) begin
      tr_a[w]   = bus.alu_a;
      tr_b[w]   = bus.alu_b;
      tr_cin[w] = bus.alu_cin;
      tr_sub[w] = bus.alu_sub;
      tr_op[w]  = bus.alu_op;
      check("rsp_valid_early", {63'd0, bus.rsp_valid}, 64'd0);
      check("req_ready_busy", {63'd0, bus.req_ready}, 64'd0);
      @(negedge clk);
    end
    check("rsp_valid_latency", {63'd0, bus.rsp_valid}, 64'd1);
  endtask

  // Hold the response for 'stall' cycles, then accept it and confirm return to IDLE.
  task automatic finish(input string name, input int stall, input logic [31:0] res,
                        input logic cout, input logic less);
    for (int s = 0; s < stall; s++) begin
      bus.req_valid = (s == 1);
      bus.req_op    = 2'b01;
      check({name, "_hold_valid"}, {63'd0, bus.rsp_valid}, 64'd1);
      check({name, "_hold_ready"}, {63'd0, bus.req_ready}, 64'd0);
      check({name, "_hold_result"}, {32'd0, bus.rsp_result}, {32'd0, res});
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    check({name, "_result"}, {32'd0, bus.rsp_result}, {32'd0, res});
    check({name, "_cout"}, {63'd0, bus.rsp_cout}, {63'd0, cout});
    check({name, "_less"}, {63'd0, bus.rsp_less}, {63'd0, less});
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check({name, "_idle_valid"}, {63'd0, bus.rsp_valid}, 64'd0);
    check({name, "_idle_ready"}, {63'd0, bus.req_ready}, 64'd1);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", {63'd0, bus.req_ready}, 64'd0);
    check("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    check("rst_rsp_result", {32'd0, bus.rsp_result}, 64'd0);
    check("rst_alu_op", {61'd0, bus.alu_op}, 64'd0);
    check("rst_alu_a", {48'd0, bus.alu_a}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
    check("post_rst_alu_cin", {63'd0, bus.alu_cin}, 64'd0);

    // AND
    issue(2'b00, 32'hAAAA_AAAA, 32'h5555_5555);
    check("and_op_w0", {61'd0, tr_op[0]}, 64'd0);
    check("and_cin_w1", {63'd0, tr_cin[1]}, 64'd0);
    finish("and", 0, 32'h0000_0000, 1'b0, 1'b0);

    // ADD with carry across words, rsp_ready held high throughout
    bus.rsp_ready = 1'b1;
    issue(2'b01, 32'h0000_FFFF, 32'h0000_0001);
    check("add_a_w0", {48'd0, tr_a[0]}, 64'h0000_FFFF);
    check("add_b_w0", {48'd0, tr_b[0]}, 64'h0000_0001);
    check("add_cin_w0", {63'd0, tr_cin[0]}, 64'd0);
    check("add_cin_w1", {63'd0, tr_cin[1]}, 64'd1);
    check("add_op_w1", {61'd0, tr_op[1]}, 64'd4);
    finish("add", 0, 32'h0001_0000, 1'b0, 1'b0);

    // SUB with signed overflow
    issue(2'b10, 32'h8000_0000, 32'h0000_0001);
    check("sub1_cin_w0", {63'd0, tr_cin[0]}, 64'd1);
    check("sub1_b_w0", {48'd0, tr_b[0]}, 64'h0000_FFFE);
    finish("sub1", 0, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // SLT on the same operands
    issue(2'b11, 32'h8000_0000, 32'h0000_0001);
    finish("slt", 0, SLT_EXP, 1'b1, 1'b1);

    // SUB with borrow, no signed less
    issue(2'b10, 32'h7FFF_FFFF, 32'hFFFF_FFFE);
    check("sub2_op_w0", {61'd0, tr_op[0]}, 64'd4);
    check("sub2_op_w1", {61'd0, tr_op[1]}, 64'd4);
    check("sub2_sub_w0", {63'd0, tr_sub[0]}, 64'd0);
    check("sub2_sub_w1", {63'd0, tr_sub[1]}, 64'd0);
    check("sub2_b_w1", {48'd0, tr_b[1]}, 64'h0000_0000);
    finish("sub2", 0, 32'h8000_0001, 1'b0, 1'b0);

    // Backpressure: 3 stalled cycles with a stray req_valid pulse
    issue(2'b01, 32'h0000_0001, 32'h0000_0002);
    finish("bp", 3, 32'h0000_0003, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("bp_no_stray_op", {63'd0, bus.rsp_valid}, 64'd0);
    check("bp_stray_alu_op", {61'd0, bus.alu_op}, 64'd0);

    // Reset during EXEC word 1
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b01;
    bus.req_a     = 32'h1234_5678;
    bus.req_b     = 32'h1111_1111;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("abort_in_exec", {61'd0, bus.alu_op}, 64'd4);
    rst = 1'b1;
    #1;
    check("abort_alu_op", {61'd0, bus.alu_op}, 64'd0);
    check("abort_alu_a", {48'd0, bus.alu_a}, 64'd0);
    check("abort_alu_b", {48'd0, bus.alu_b}, 64'd0);
    check("abort_rsp_result", {32'd0, bus.rsp_result}, 64'd0);
    check("abort_req_ready", {63'd0, bus.req_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("abort_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
      @(negedge clk);
    end
    issue(2'b01, 32'h1234_5678, 32'h1111_1111);
    finish("after_abort", 0, 32'h2345_6789, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
